result_buffer: RTL and testbench

RESULT_BUFFER -- requirements
Module: result_buffer

---
 rtl/result_buffer_pkg.sv | 15 +
 rtl/result_buffer_if.sv | 41 ++++
 rtl/result_fifo_mem.sv | 26 ++
 rtl/result_buffer.sv | 167 ++++++++++++++++
 tb/tb_result_buffer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/result_buffer_pkg.sv
// Shared definitions for the result/instruction buffer family: default geometry,
// datapath width and the burst FSM state encoding.
package result_buffer_pkg;

    localparam int DATA_WIDTH  = 64;
    localparam int QUEUE_DEPTH = 64;
    localparam int ADDR_WIDTH  = 6;
    localparam int BURST_LEN   = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } buf_state_e;

endpackage : result_buffer_pkg

// File: rtl/result_buffer_if.sv
// Bundle of the producer-side write port and consumer-side burst port of result_buffer.
interface result_buffer_if #(
    parameter int ADDR_WIDTH = result_buffer_pkg::ADDR_WIDTH
);
    import result_buffer_pkg::*;

    logic [DATA_WIDTH-1:0] result_in;
    logic                  result_valid;
    logic                  buffer_full;
    logic                  drain;
    logic [DATA_WIDTH-1:0] interface_output;
    logic                  output_valid;
    logic                  output_ready;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;

    modport master (
        output result_in,
        output result_valid,
        output drain,
        output output_ready,
        input  buffer_full,
        input  interface_output,
        input  output_valid,
        input  count,
        input  overflow
    );

    modport slave (
        input  result_in,
        input  result_valid,
        input  drain,
        input  output_ready,
        output buffer_full,
        output interface_output,
        output output_valid,
        output count,
        output overflow
    );

endinterface : result_buffer_if

// File: rtl/result_fifo_mem.sv
// Storage array for result_buffer: one synchronous write port, one asynchronous read port.
module result_fifo_mem #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_r [DEPTH];

    // Write port; contents are not reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule : result_fifo_mem

// File: rtl/result_buffer.sv
// Result FIFO that releases stored words to the external interface in bursts,
// either when BURST_LEN words are queued or when a drain request flushes it.
module result_buffer #(
    parameter int QUEUE_DEPTH = result_buffer_pkg::QUEUE_DEPTH,
    parameter int ADDR_WIDTH  = result_buffer_pkg::ADDR_WIDTH,
    parameter int BURST_LEN   = result_buffer_pkg::BURST_LEN
) (
    input  logic           clk,
    input  logic           rst,
    result_buffer_if.slave bus
);
    import result_buffer_pkg::*;

    localparam logic [ADDR_WIDTH:0]   DEPTH_C    = (ADDR_WIDTH+1)'(QUEUE_DEPTH);
    localparam logic [ADDR_WIDTH:0]   BURST_C    = (ADDR_WIDTH+1)'(BURST_LEN);
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO_C = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE_C  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO_C = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST_C = ADDR_WIDTH'(QUEUE_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] head_r;
    logic [ADDR_WIDTH-1:0] tail_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic [ADDR_WIDTH:0]   burst_cnt_r;
    buf_state_e            state_r;
    logic                  drain_pending_r;
    logic                  overflow_r;
    logic                  output_valid_r;
    logic [DATA_WIDTH-1:0] interface_output_r;

    logic [ADDR_WIDTH-1:0] head_inc_s;
    logic [ADDR_WIDTH-1:0] tail_inc_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic [ADDR_WIDTH:0]   count_next_s;
    logic [ADDR_WIDTH:0]   burst_cnt_next_s;
    buf_state_e            state_next_s;
    logic                  drain_pending_next_s;
    logic                  output_valid_next_s;
    logic [DATA_WIDTH-1:0] interface_output_next_s;
    logic                  full_s;
    logic                  wr_accept_s;
    logic                  handshake_s;
    logic                  trigger_s;
    logic                  burst_last_s;

    assign full_s      = (count_r == DEPTH_C);
    assign wr_accept_s = bus.result_valid && !full_s;
    assign handshake_s = output_valid_r && bus.output_ready;
    assign trigger_s   = (count_r >= BURST_C) || (drain_pending_r && (count_r != CNT_ZERO_C));
    // A burst ends on the word that completes BURST_LEN or on the last stored word;
    // a write landing in that same cycle waits for a fresh trigger.
    assign burst_last_s = ((burst_cnt_r + CNT_ONE_C) >= BURST_C) || (count_r == CNT_ONE_C);

    assign head_inc_s = (head_r == PTR_LAST_C) ? PTR_ZERO_C : (head_r + PTR_ONE_C);
    assign tail_inc_s = (tail_r == PTR_LAST_C) ? PTR_ZERO_C : (tail_r + PTR_ONE_C);
    assign rd_addr_s  = ((state_r == ST_SEND) && handshake_s) ? head_inc_s : head_r;

    result_fifo_mem #(
        .DEPTH (QUEUE_DEPTH),
        .AW    (ADDR_WIDTH),
        .DW    (DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_accept_s && !rst),
        .wr_addr (tail_r),
        .wr_data (bus.result_in),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    // Occupancy and drain bookkeeping for the coming cycle.
    always_comb begin
        count_next_s         = count_r;
        drain_pending_next_s = drain_pending_r;
        case ({wr_accept_s, handshake_s})
            2'b10:   count_next_s = count_r + CNT_ONE_C;
            2'b01:   count_next_s = count_r - CNT_ONE_C;
            default: count_next_s = count_r;
        endcase
        if (count_next_s == CNT_ZERO_C) begin
            drain_pending_next_s = 1'b0;
        end else if (bus.drain && (count_r != CNT_ZERO_C)) begin
            drain_pending_next_s = 1'b1;
        end else begin
            drain_pending_next_s = drain_pending_r;
        end
    end

    // Burst FSM next state and registered output word/valid.
    always_comb begin
        state_next_s            = state_r;
        output_valid_next_s     = output_valid_r;
        interface_output_next_s = interface_output_r;
        burst_cnt_next_s        = burst_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (trigger_s) begin
                    state_next_s            = ST_SEND;
                    output_valid_next_s     = 1'b1;
                    interface_output_next_s = rd_data_s;
                    burst_cnt_next_s        = CNT_ZERO_C;
                end else begin
                    output_valid_next_s = 1'b0;
                end
            end
            ST_SEND: begin
                if (handshake_s) begin
                    burst_cnt_next_s = burst_cnt_r + CNT_ONE_C;
                    if (burst_last_s) begin
                        state_next_s        = ST_IDLE;
                        output_valid_next_s = 1'b0;
                    end else begin
                        output_valid_next_s     = 1'b1;
                        interface_output_next_s = rd_data_s;
                    end
                end else begin
                    output_valid_next_s = 1'b1;
                end
            end
            default: begin
                state_next_s        = ST_IDLE;
                output_valid_next_s = 1'b0;
                burst_cnt_next_s    = CNT_ZERO_C;
            end
        endcase
    end

    // State, pointer and flag registers; rst overrides any same-cycle activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r             <= PTR_ZERO_C;
            tail_r             <= PTR_ZERO_C;
            count_r            <= CNT_ZERO_C;
            burst_cnt_r        <= CNT_ZERO_C;
            state_r            <= ST_IDLE;
            drain_pending_r    <= 1'b0;
            overflow_r         <= 1'b0;
            output_valid_r     <= 1'b0;
            interface_output_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if (wr_accept_s) begin
                tail_r <= tail_inc_s;
            end
            if (handshake_s) begin
                head_r <= head_inc_s;
            end
            if (bus.result_valid && full_s) begin
                overflow_r <= 1'b1;
            end
            count_r            <= count_next_s;
            burst_cnt_r        <= burst_cnt_next_s;
            state_r            <= state_next_s;
            drain_pending_r    <= drain_pending_next_s;
            output_valid_r     <= output_valid_next_s;
            interface_output_r <= interface_output_next_s;
        end
    end

    assign bus.buffer_full      = full_s;
    assign bus.interface_output = interface_output_r;
    assign bus.output_valid     = output_valid_r;
    assign bus.count            = count_r;
    assign bus.overflow         = overflow_r;

endmodule : result_buffer

// File: tb/tb_result_buffer.sv
// Self-checking bench for result_buffer: cycle table for a full burst, scoreboard for
// output ordering, and directed sequences for drain, back-pressure, overflow, wrap and reset.
module tb_result_buffer;
    import result_buffer_pkg::*;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [63:0] exp_q [$];

    result_buffer_if #(.ADDR_WIDTH(6)) bus ();

    result_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic        dr;
        logic        rdy;
        logic [6:0]  e_cnt;
        logic        e_vld;
        logic        e_full;
        logic [63:0] e_out;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, optionally recording an expected output word.
    task automatic step(input logic v, input logic [63:0] d, input logic dr,
                        input logic rdy, input logic do_push);
        bus.result_valid = v;
        bus.result_in    = d;
        bus.drain        = dr;
        bus.output_ready = rdy;
        if (do_push) exp_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input int budget, input string name);
        int n = 0;
        while (bus.count != 7'd0 && n < budget) begin
            step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
            n++;
        end
        check(name, 64'(bus.count), 64'd0);
    endtask

    // Scoreboard: every handshake must deliver the oldest expected word.
    always @(negedge clk) begin
        if (!rst && bus.output_valid && bus.output_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", bus.interface_output, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("sb_order", bus.interface_output, exp_q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++)
            vecs[i] = '{v:1'b1, d:64'(i + 1), dr:1'b0, rdy:1'b1, e_cnt:7'(i + 1),
                        e_vld:1'b0, e_full:1'b0, e_out:64'd0};
        for (int k = 0; k < 8; k++)
            vecs[8 + k] = '{v:1'b0, d:64'd0, dr:1'b0, rdy:1'b1, e_cnt:7'(8 - k),
                            e_vld:1'b1, e_full:1'b0, e_out:64'(k + 1)};
        vecs[16] = '{v:1'b0, d:64'd0, dr:1'b0, rdy:1'b1, e_cnt:7'd0,
                     e_vld:1'b0, e_full:1'b0, e_out:64'd0};

        rst = 1'b1;
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_valid", 64'(bus.output_valid), 64'd0);
        check("rst_full", 64'(bus.buffer_full), 64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);
        check("rst_output", bus.interface_output, 64'd0);
        rst = 1'b0;

        // Threshold burst of 0x1..0x8, cycle by cycle.
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].dr, vecs[i].rdy, vecs[i].v);
            check("tbl_count", 64'(bus.count), 64'(vecs[i].e_cnt));
            check("tbl_valid", 64'(bus.output_valid), 64'(vecs[i].e_vld));
            check("tbl_full", 64'(bus.buffer_full), 64'(vecs[i].e_full));
            if (vecs[i].e_vld) check("tbl_output", bus.interface_output, vecs[i].e_out);
        end

        // Below threshold nothing moves until drain.
        for (int i = 0; i < 3; i++) step(1'b1, 64'h11 + 64'(i), 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
            check("nodrain_valid", 64'(bus.output_valid), 64'd0);
        end
        step(1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
        check("drain_pending_set", 64'(dut.drain_pending_r), 64'd1);
        wait_empty(20, "drain_empty");
        check("drain_pending_clr", 64'(dut.drain_pending_r), 64'd0);
        check("drain_valid_low", 64'(bus.output_valid), 64'd0);

        // Word written in the cycle the FIFO empties waits for a new trigger.
        step(1'b1, 64'h31, 1'b0, 1'b1, 1'b1);
        step(1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        check("late_first_valid", 64'(bus.output_valid), 64'd1);
        check("late_first_out", bus.interface_output, 64'h31);
        step(1'b1, 64'h32, 1'b0, 1'b1, 1'b1);
        check("late_gap_valid", 64'(bus.output_valid), 64'd0);
        check("late_gap_count", 64'(bus.count), 64'd1);
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        check("late_second_valid", 64'(bus.output_valid), 64'd1);
        check("late_second_out", bus.interface_output, 64'h32);
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        check("late_end_count", 64'(bus.count), 64'd0);
        check("late_end_dp", 64'(dut.drain_pending_r), 64'd0);

        // Drain on an empty buffer does nothing.
        step(1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
        check("empty_drain_dp", 64'(dut.drain_pending_r), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
            check("empty_drain_valid", 64'(bus.output_valid), 64'd0);
        end

        // Back-pressure holds the presented word.
        for (int i = 0; i < 8; i++) step(1'b1, 64'h21 + 64'(i), 1'b0, 1'b0, 1'b1);
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
            check("hold_valid", 64'(bus.output_valid), 64'd1);
            check("hold_out", bus.interface_output, 64'h21);
        end
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        check("release_out", bus.interface_output, 64'h22);
        check("release_count", 64'(bus.count), 64'd7);
        wait_empty(30, "release_empty");

        // Fill to capacity; the 65th word is dropped.
        for (int i = 0; i < 65; i++) begin
            step(1'b1, 64'h100 + 64'(i), 1'b0, 1'b0, (i < 64));
            if (i == 62) check("fill63_full", 64'(bus.buffer_full), 64'd0);
            if (i == 63) begin
                check("fill64_full", 64'(bus.buffer_full), 64'd1);
                check("fill64_count", 64'(bus.count), 64'd64);
                check("fill64_overflow", 64'(bus.overflow), 64'd0);
            end
        end
        check("drop_count", 64'(bus.count), 64'd64);
        check("drop_overflow", 64'(bus.overflow), 64'd1);
        wait_empty(200, "full_empty");
        check("overflow_sticky", 64'(bus.overflow), 64'd1);

        rst = 1'b1;
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check("rst2_overflow", 64'(bus.overflow), 64'd0);

        // Streaming writes across the pointer wrap.
        for (int i = 0; i < 70; i++) step(1'b1, 64'h1000 + 64'(i), 1'b0, 1'b1, 1'b1);
        step(1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
        wait_empty(60, "wrap_empty");
        check("wrap_tail", 64'(dut.tail_r), 64'd6);
        check("wrap_head", 64'(dut.head_r), 64'd6);

        // Reset in the middle of a burst with ten words stored.
        for (int i = 0; i < 10; i++) step(1'b1, 64'h200 + 64'(i), 1'b0, 1'b0, 1'b0);
        check("pre_rst_count", 64'(bus.count), 64'd10);
        check("pre_rst_valid", 64'(bus.output_valid), 64'd1);
        rst = 1'b1;
        step(1'b1, 64'hDEAD, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        check("midrst_count", 64'(bus.count), 64'd0);
        check("midrst_valid", 64'(bus.output_valid), 64'd0);
        check("midrst_overflow", 64'(bus.overflow), 64'd0);
        check("midrst_state", 64'(dut.state_r), 64'(ST_IDLE));
        check("midrst_out", bus.interface_output, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
            check("post_rst_valid", 64'(bus.output_valid), 64'd0);
        end

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_result_buffer
